// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer that lets two requesters share one combinational ALU.
// Each accepted operation is issued from registered operands and answered with one tagged response.
module alu_share_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_op,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_op,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [WIDTH-1:0]  rsp_result,
  output logic              rsp_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic              last;
  logic [CTRL_W-1:0] op_p0;
  logic [WIDTH-1:0]  a_p0;
  logic [WIDTH-1:0]  b_p0;
  logic              id_p0;
  logic              gnt0;
  logic              gnt1;

  // Contention goes to whichever requester was not served last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE) begin
      gnt0 = req0_valid && (!req1_valid || last);
      gnt1 = req1_valid && (!req0_valid || !last);
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign alu_ctrl = op_p0;
  assign alu_a    = a_p0;
  assign alu_b    = b_p0;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state      <= IDLE;
      last       <= 1'b1;
      op_p0      <= '0;
      a_p0       <= '0;
      b_p0       <= '0;
      id_p0      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      unique case (state)
        // Issue stage: operands are sampled only on the grant edge
        IDLE: begin
          if (gnt0 || gnt1) begin
            op_p0 <= gnt1 ? req1_op : req0_op;
            a_p0  <= gnt1 ? req1_a  : req0_a;
            b_p0  <= gnt1 ? req1_b  : req0_b;
            last  <= gnt1;
            id_p0 <= gnt1;
            state <= EXEC;
          end
        end
        // Capture stage: ALU output settles during EXEC and is registered here
        EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_id     <= id_p0;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        // Response stage: hold until the consumer takes it
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with an adder standing in for the ALU.
module tb_alu_share_arbiter;

  localparam int WIDTH  = 32;
  localparam int CTRL_W = 4;

  logic              sys_clk = 1'b0;
  logic              rst;
  logic              req0_valid, req0_ready;
  logic [CTRL_W-1:0] req0_op;
  logic [WIDTH-1:0]  req0_a, req0_b;
  logic              req1_valid, req1_ready;
  logic [CTRL_W-1:0] req1_op;
  logic [WIDTH-1:0]  req1_a, req1_b;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [WIDTH-1:0]  alu_a, alu_b, alu_result;
  logic              alu_zero;
  logic              rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [WIDTH-1:0]  rsp_result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 sys_clk = ~sys_clk;

  assign alu_result = alu_a + alu_b;
  assign alu_zero   = (alu_result == '0);

  alu_share_arbiter #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .alu_ctrl   (alu_ctrl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic id,
                           input logic [WIDTH-1:0] res, input logic z);
    check_val({tag, "_valid"},  rsp_valid,  v);
    check_val({tag, "_id"},     rsp_id,     id);
    check_val({tag, "_result"}, rsp_result, res);
    check_val({tag, "_zero"},   rsp_zero,   z);
  endtask

  task automatic check_ready(input string tag, input logic r0, input logic r1);
    check_val({tag, "_rdy0"}, req0_ready, r0);
    check_val({tag, "_rdy1"}, req1_ready, r1);
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;

    // Reset then idle
    step(); step();
    rst = 1'b0;
    #1;
    check_rsp("rst", 1'b0, 1'b0, 32'd0, 1'b0);
    check_val("rst_ctrl", alu_ctrl, 4'd0);
    check_val("rst_a", alu_a, 32'd0);
    check_val("rst_b", alu_b, 32'd0);
    check_ready("rst", 1'b0, 1'b0);
    step(); step();
    check_val("idle_valid", rsp_valid, 1'b0);
    check_ready("idle", 1'b0, 1'b0);

    // Single request from requester 0
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 4'd5; req0_a = 32'd2; req0_b = 32'd6;
    #1;
    check_ready("single_acc", 1'b1, 1'b0);
    step();
    req0_valid = 1'b0;
    #1;
    check_val("single_ctrl", alu_ctrl, 4'd5);
    check_val("single_a", alu_a, 32'd2);
    check_val("single_b", alu_b, 32'd6);
    check_val("single_exec_v", rsp_valid, 1'b0);
    check_ready("single_exec", 1'b0, 1'b0);
    step();
    check_rsp("single_rsp", 1'b1, 1'b0, 32'd8, 1'b0);
    step();
    check_val("single_done", rsp_valid, 1'b0);

    // Single request from requester 1 (leaves requester 1 as last served)
    req1_valid = 1'b1; req1_op = 4'd3; req1_a = 32'd10; req1_b = 32'd20;
    #1;
    check_ready("single1_acc", 1'b0, 1'b1);
    step();
    req1_valid = 1'b0;
    step();
    check_rsp("single1_rsp", 1'b1, 1'b1, 32'd30, 1'b0);
    step();

    // Contention: both held valid for four operations
    req0_valid = 1'b1; req0_op = 4'd2; req0_a = 32'd1; req0_b = 32'd1;
    req1_valid = 1'b1; req1_op = 4'd6; req1_a = 32'd3; req1_b = 32'hFFFF_FFFD;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_ready($sformatf("rr%0d_idle", i), (i % 2) == 0, (i % 2) == 1);
      step();
      check_ready($sformatf("rr%0d_exec", i), 1'b0, 1'b0);
      step();
      if ((i % 2) == 0)
        check_rsp($sformatf("rr%0d", i), 1'b1, 1'b0, 32'd2, 1'b0);
      else
        check_rsp($sformatf("rr%0d", i), 1'b1, 1'b1, 32'd0, 1'b1);
      step();
    end

    // Backpressure: requester 0 wins, response held 5 cycles, requester 1 waits
    rsp_ready = 1'b0;
    #1;
    check_ready("bp_idle", 1'b1, 1'b0);
    step(); step();
    check_rsp("bp_first", 1'b1, 1'b0, 32'd2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_rsp($sformatf("bp_hold%0d", i), 1'b1, 1'b0, 32'd2, 1'b0);
      check_ready($sformatf("bp_hold%0d", i), 1'b0, 1'b0);
    end
    rsp_ready = 1'b1;
    #1;
    check_ready("bp_release", 1'b0, 1'b0);
    step();
    #1;
    check_ready("bp_next", 1'b0, 1'b1);
    step(); step();
    check_rsp("bp_req1", 1'b1, 1'b1, 32'd0, 1'b1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();

    // Reset while in EXEC discards the operation
    req0_valid = 1'b1; req0_op = 4'd1; req0_a = 32'd7; req0_b = 32'd8;
    step();
    req0_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_rsp("mid_rst", 1'b0, 1'b0, 32'd0, 1'b0);
    check_val("mid_rst_ctrl", alu_ctrl, 4'd0);
    check_val("mid_rst_a", alu_a, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val($sformatf("mid_rst_quiet%0d", i), rsp_valid, 1'b0);
    end
    req1_valid = 1'b1; req1_op = 4'd2; req1_a = 32'd4; req1_b = 32'd5;
    #1;
    check_ready("post_rst_acc", 1'b0, 1'b1);
    step();
    req1_valid = 1'b0;
    step();
    check_rsp("post_rst", 1'b1, 1'b1, 32'd9, 1'b0);
    step();

    // Operand isolation: payload change after grant must not reach the ALU
    req0_valid = 1'b1; req0_op = 4'd4; req0_a = 32'd7; req0_b = 32'd0;
    step();
    req0_valid = 1'b0; req0_a = 32'd9;
    #1;
    check_val("iso_exec_a", alu_a, 32'd7);
    step();
    check_rsp("iso", 1'b1, 1'b0, 32'd7, 1'b0);
    check_val("iso_resp_a", alu_a, 32'd7);
    step(); step();
    check_val("iso_idle_a", alu_a, 32'd7);
    check_val("iso_idle_ctrl", alu_ctrl, 4'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-requester arbiter and sequencer for the shared combinational ALU32Bit. It accepts operation requests (ALUControl, A, B) from two clients over valid/ready handshakes and grants them round-robin. It drives the ALU from registered operands, captures ALUResult/Zero, and returns each result to a single response port tagged with the requester ID. It sits between the instruction-issue logic and the ALU instance, so the ALU inputs are never driven by two sources.

## Interface
- WIDTH, 32, operand/result width
- CTRL_W, 4, ALUControl width
- sys_clk  in  1  system clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  CTRL_W  requester 0 ALUControl code
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1
- alu_ctrl  out  CTRL_W  to ALU ALUControl
- alu_a, alu_b  out  WIDTH  to ALU A, B
- alu_result  in  WIDTH  from ALU ALUResult (combinational)
- alu_zero  in  1  from ALU Zero
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that issued the operation
- rsp_result  out  WIDTH  captured ALU result
- rsp_zero  out  1  captured Zero flag

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant logic is combinational from req*_valid and the round-robin pointer `last`.
  - If only one requester is valid, grant it.
  - If both are valid, grant the requester that is not `last`.
  - Assert only the granted requester's req*_ready. Assert it in IDLE only.
  - On grant: latch op/a/b into the operand registers, set `last` to the granted ID, latch the ID, go to EXEC.
  - If no requester is valid, stay in IDLE.
- EXEC:
  - The operand registers drive alu_ctrl/alu_a/alu_b.
  - At the clock edge, capture alu_result into rsp_result and alu_zero into rsp_zero, set rsp_id and rsp_valid=1, go to RESP.
- RESP:
  - Hold rsp_* stable while rsp_valid && !rsp_ready.
  - On rsp_valid && rsp_ready: clear rsp_valid and go to IDLE.
  - Arbitration does not start until IDLE.
- alu_ctrl/alu_a/alu_b are always driven from the operand registers. They hold the last issued operation in IDLE/RESP and change only on a grant.
- Requester rule: payload must stay stable while req_valid && !req_ready. The arbiter samples the payload only on the grant cycle.
- The arbiter never drops or reorders an accepted operation. Exactly one response is produced per grant.
- No arithmetic is performed in this block. The result is the ALU's WIDTH-bit output passed unmodified.

## Timing
- Reset values, the cycle after rst=1:
  - State IDLE, `last`=1 (requester 0 wins the first contention).
  - Operand registers 0, so alu_ctrl=0, alu_a=0, alu_b=0.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0.
  - req0_ready/req1_ready follow from IDLE: they reflect current valids immediately after reset.
- rst has priority over all transitions. Reset in EXEC or RESP discards the in-flight operation, and no response is ever produced for it.
- Latency: a grant at edge N puts the operands on the ALU after N. The result is captured at N+1, and rsp_valid is high in the cycle after N+1.
- Minimum issue interval is 3 cycles per operation (IDLE, EXEC, RESP with rsp_ready=1).
- Response backpressure stalls in RESP indefinitely, and neither req*_ready is asserted meanwhile.
- Simultaneous valids in IDLE: exactly one ready is asserted. Never both.
- A requester that deasserts valid before being granted is simply not granted. Nothing is latched.

## Test plan
The bench ALU stub drives alu_result = alu_a + alu_b and alu_zero = (alu_result == 0).
- Reset then idle: rst for 2 cycles, no valids -> all outputs 0, state remains IDLE, req*_ready=0.
- Single request: req0 op=5, a=2, b=6, rsp_ready=1 -> req0_ready is high on the accept cycle, and two cycles later rsp_valid=1, rsp_id=0, rsp_result=8, rsp_zero=0.
- Contention fairness: both requesters held valid for 4 operations (req0 a=b=1, req1 a=3, b=0xFFFFFFFD) -> grants alternate 0,1,0,1. req1 responses carry rsp_result=0, rsp_zero=1.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* is stable, both readies stay 0, and the pending req1 is granted only after the rsp handshake.
- Reset mid-operation: assert rst in EXEC -> no rsp_valid follows, outputs return to reset values, and the next request is served normally with rsp_id correct.
- Operand isolation: req0 a=7 is granted, then req0_a changes to 9 during EXEC -> rsp_result reflects 7, and alu_a stays 7 until the next grant.
